// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers, with a WAIT watchdog.
// Optional per-requester packet lock (req_lock_i) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]        req_lock_i,
`endif
    output logic [NREQ-1:0]        req_ready_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic                   tx_start_o,
    output logic [DATA_W-1:0]      tx_data_o,
    input  logic                   tx_end_i,
    output logic                   timeout_o
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tx_start_q, tx_start_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              lock_q, lock_d;

    logic [DATA_W-1:0] req_data [NREQ];
    logic [NREQ-1:0]   lock_bits;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_found;
    logic [IDX_W-1:0]  acc_idx;
    logic              accept;
    logic              lock_hold;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef UART_ARB_LOCK_EN
    assign lock_bits = req_lock_i;
`else
    assign lock_bits = '0;
`endif

    // First valid requester after the previous owner, wrapping modulo NREQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(last_grant_q) + off) % NREQ);
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // A held lock pins arbitration to the previous owner, even while its valid is low.
    always_comb begin
        lock_hold = lock_q && lock_bits[last_grant_q];
        accept    = 1'b0;
        acc_idx   = rr_idx;
        if (state_q == S_IDLE) begin
            if (lock_hold) begin
                accept  = req_valid_i[last_grant_q];
                acc_idx = last_grant_q;
            end else begin
                accept  = rr_found;
            end
        end
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[acc_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        tx_start_d   = 1'b0;
        timeout_d    = 1'b0;
        busy_d       = busy_q;
        lock_d       = lock_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d          = '0;
                    grant_d[acc_idx] = 1'b1;
                    last_grant_d     = acc_idx;
                    data_d           = req_data[acc_idx];
                    lock_d           = lock_bits[acc_idx];
                    tx_start_d       = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = S_START;
                end else if (!lock_hold) begin
                    lock_d = 1'b0;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (tx_end_i) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_LAST;
            data_q       <= '0;
            tx_start_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            tx_start_q   <= tx_start_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            lock_q       <= lock_d;
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = data_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed and random frames against a round-robin reference model.
// Exercises the packet lock as well when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 128;

    logic              sysclk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*DW-1:0] req_data_i;
    logic [NREQ-1:0]   req_lock_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              tx_start_o;
    logic [DW-1:0]     tx_data_o;
    logic              tx_end_i;
    logic              timeout_o;

    int n_assert = 0;
    int n_fail   = 0;
    int model_last = NREQ - 1;
    int lock_owner = -1;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
`ifdef UART_ARB_LOCK_EN
        .req_lock_i  (req_lock_i),
`endif
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_end_i    (tx_end_i),
        .timeout_o   (timeout_o)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: a live lock pins the owner; otherwise first valid after the last owner.
    function automatic int model_winner(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk);
        if (lock_owner >= 0 && lk[lock_owner]) begin
            return v[lock_owner] ? lock_owner : -1;
        end
        for (int off = 1; off <= NREQ; off++) begin
            int k;
            k = (model_last + off) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Entered just after a negedge with the DUT idle; returns just after a negedge, idle again.
    // end_k < 0 means the UART never answers and the watchdog must fire.
    task automatic run_frame(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk,
                             input logic [31:0] d, input int end_k, input bit spurious);
        int w;
        logic [DW-1:0] exp_byte;
        req_valid_i = v;
        req_lock_i  = lk;
        req_data_i  = d;
        #1;
        w = model_winner(v, lk);
        if (lock_owner >= 0 && !lk[lock_owner]) lock_owner = -1;
        chk("ready_accept", 32'(req_ready_o), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
        if (w < 0) w = 0;
        exp_byte   = d[w*DW +: DW];
        model_last = w;
        lock_owner = lk[w] ? w : -1;
        $display("frame: winner=%0d valid=%b lock=%b data=%02h end_k=%0d", w, v, lk, exp_byte, end_k);
        @(posedge sysclk);
        @(negedge sysclk);
        tx_end_i = spurious;
        #1;
        chk("tx_start", 32'(tx_start_o), 32'd1);
        chk("tx_data", 32'(tx_data_o), 32'(exp_byte));
        chk("grant", 32'(grant_o), 32'd1 << w);
        chk("ready_start", 32'(req_ready_o), 32'd0);
        @(negedge sysclk);
        tx_end_i = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (k == 0) chk("tx_start_wait", 32'(tx_start_o), 32'd0);
            chk("busy_wait", 32'(busy_o), 32'd1);
            if (k == end_k) tx_end_i = 1'b1;
            @(negedge sysclk);
            tx_end_i = 1'b0;
            if (k == end_k) break;
        end
        #1;
        chk("busy_end", 32'(busy_o), 32'd0);
        chk("grant_end", 32'(grant_o), 32'd0);
        chk("timeout", 32'(timeout_o), (end_k < 0) ? 32'd1 : 32'd0);
        chk("tx_data_hold", 32'(tx_data_o), 32'(exp_byte));
        if (end_k < 0) lock_owner = -1;
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        int r;
        int ek;
        reset       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_lock_i  = '0;
        tx_end_i    = 1'b0;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_start", 32'(tx_start_o), 32'd0);
        chk("rst_data", 32'(tx_data_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);

        // Fairness: all valid, expect A0,A1,A2,A3,A0.
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, 4'b0000, 32'hA3A2A1A0, 3 + i, 1'b0);
            chk("rotate_byte", 32'(tx_data_o), 32'hA0 + 32'(i % NREQ));
        end

        // Contention after grant 2: 3, 0, 1.
        run_frame(4'b0100, 4'b0000, 32'h00440000, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_frame(4'b1011, 4'b0000, 32'h33002211, 1, 1'b0);
            chk("contend_grant", 32'(model_last), (i == 0) ? 32'd3 : 32'(i - 1));
        end

        // Single requester, UART answers 100 cycles after start.
        run_frame(4'b0001, 4'b0000, 32'h00000055, 99, 1'b0);
        chk("single_byte", 32'(tx_data_o), 32'h55);

        // Watchdog, then the next request is still served; tx_end on the last count wins.
        run_frame(4'b0010, 4'b0000, 32'h00006600, -1, 1'b0);
        run_frame(4'b0100, 4'b0000, 32'h00770000, TO - 1, 1'b1);

        // Reset in the middle of WAIT abandons the frame.
        req_valid_i = 4'b1000;
        req_data_i  = 32'h99000000;
        @(posedge sysclk);
        repeat (3) @(negedge sysclk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        reset       = 1'b1;
        req_valid_i = '0;
        @(negedge sysclk);
        reset = 1'b0;
        #1;
        chk("midrst_grant", 32'(grant_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_data", 32'(tx_data_o), 32'd0);
        chk("midrst_timeout", 32'(timeout_o), 32'd0);
        model_last = NREQ - 1;
        lock_owner = -1;
        tx_end_i = 1'b1;
        @(negedge sysclk);
        tx_end_i = 1'b0;
        #1;
        chk("stray_end_busy", 32'(busy_o), 32'd0);
        chk("stray_end_grant", 32'(grant_o), 32'd0);
        run_frame(4'b1111, 4'b0000, 32'hDDCCBBAA, 0, 1'b0);
        chk("after_rst_first", 32'(model_last), 32'd0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            rv = 4'($urandom_range(1, 15));
            r  = $urandom_range(0, 9);
            ek = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 10);
            run_frame(rv, 4'b0000, $urandom, ek, ($urandom_range(0, 3) == 0));
        end

`ifdef UART_ARB_LOCK_EN
        // Requester 1 locks three bytes while requester 0 competes.
        model_last = 0;
        run_frame(4'b0010, 4'b0000, 32'h00000000, 0, 1'b0);
        run_frame(4'b0010, 4'b0010, 32'h00001100, 2, 1'b0);
        run_frame(4'b0011, 4'b0010, 32'h00002200, 2, 1'b0);
        chk("lock_second", 32'(model_last), 32'd1);
        run_frame(4'b0011, 4'b0010, 32'h00003300, 2, 1'b0);
        chk("lock_third", 32'(model_last), 32'd1);
        req_valid_i = 4'b0101;
        req_lock_i  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lock_blocked", 32'(req_ready_o), 32'd0);
            @(negedge sysclk);
        end
        run_frame(4'b0101, 4'b0000, 32'h00440000, 1, 1'b0);
        chk("lock_release", 32'(model_last), 32'd2);
`endif

        req_valid_i = '0;
        repeat (2) @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
